// File: rtl/addsub_iter_pkg.sv
// addsub_iter shared types: FSM encoding, datapath width, slice count.
// Optional signed-overflow flag is enabled by ADDSUB_OVERFLOW_EN.
package addsub_iter_pkg;

  localparam int DATA_W = 32;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } state_e;

  function automatic int slice_cnt(input int sw);
    return DATA_W / sw;
  endfunction

  // A single-slice build still needs a 1-bit index register.
  function automatic int idx_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/addsub_slice.sv
// Combinational W-bit ripple-carry adder slice.
// Bit cells are plain full adders chained on the carry.
module addsub_slice #(
  parameter int W = 8
) (
  input  logic [W-1:0] a_i,
  input  logic [W-1:0] b_i,
  input  logic         ci_i,
  output logic [W-1:0] s_o,
  output logic         co_o
);

  logic [W:0] c;

  assign c[0] = ci_i;

  for (genvar i = 0; i < W; i++) begin : g_fa
    logic p;
    assign p        = a_i[i] ^ b_i[i];
    assign s_o[i]   = p ^ c[i];
    assign c[i+1]   = (a_i[i] & b_i[i]) | (p & c[i]);
  end

  assign co_o = c[W];

endmodule

// File: rtl/addsub_iter.sv
// Iterative 32-bit add/sub, SLICE_W bits per cycle, valid/ready handshakes.
// Define ADDSUB_OVERFLOW_EN to compute the signed-overflow flag 'of'.
module addsub_iter
  import addsub_iter_pkg::*;
#(
  parameter int SLICE_W = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] a,
  input  logic [DATA_W-1:0] b,
  input  logic              sub,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] result,
  output logic              zf,
  output logic              cf,
  output logic              of
);

  localparam int N  = slice_cnt(SLICE_W);
  localparam int IW = idx_w(N);

  state_e            state_q;
  logic [DATA_W-1:0] a_q;
  logic [DATA_W-1:0] b_q;
  logic [DATA_W-1:0] res_q;
  logic [DATA_W-1:0] res_d;
  logic              c_q;
  logic [IW-1:0]     idx_q;
  logic              in_ready_q;
  logic              out_valid_q;
  logic              zf_q;
  logic              cf_q;

  logic [SLICE_W-1:0] sa;
  logic [SLICE_W-1:0] sb;
  logic [SLICE_W-1:0] ss;
  logic               sco;
  logic               last;

  always_comb begin
    sa    = a_q[int'(idx_q)*SLICE_W +: SLICE_W];
    sb    = b_q[int'(idx_q)*SLICE_W +: SLICE_W];
    res_d = res_q;
    res_d[int'(idx_q)*SLICE_W +: SLICE_W] = ss;
    last  = (idx_q == IW'(N-1));
  end

  addsub_slice #(
    .W (SLICE_W)
  ) u_slice (
    .a_i  (sa),
    .b_i  (sb),
    .ci_i (c_q),
    .s_o  (ss),
    .co_o (sco)
  );

`ifdef ADDSUB_OVERFLOW_EN
  logic of_q;
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= IDLE;
      a_q         <= '0;
      b_q         <= '0;
      res_q       <= '0;
      c_q         <= 1'b0;
      idx_q       <= '0;
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
      zf_q        <= 1'b0;
      cf_q        <= 1'b0;
`ifdef ADDSUB_OVERFLOW_EN
      of_q        <= 1'b0;
`endif
    end else begin
      case (state_q)
        IDLE: begin
          if (in_valid) begin
            a_q        <= a;
            b_q        <= b ^ {DATA_W{sub}};
            c_q        <= sub;
            idx_q      <= '0;
            in_ready_q <= 1'b0;
            state_q    <= BUSY;
          end
        end
        BUSY: begin
          res_q <= res_d;
          c_q   <= sco;
          idx_q <= idx_q + IW'(1);
          if (last) begin
            idx_q       <= '0;
            state_q     <= DONE;
            out_valid_q <= 1'b1;
            zf_q        <= (res_d == '0);
            cf_q        <= sco;
`ifdef ADDSUB_OVERFLOW_EN
            of_q <= (a_q[DATA_W-1] == b_q[DATA_W-1]) &&
                    (res_d[DATA_W-1] != a_q[DATA_W-1]);
`endif
          end
        end
        DONE: begin
          if (out_ready) begin
            out_valid_q <= 1'b0;
            in_ready_q  <= 1'b1;
            state_q     <= IDLE;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign in_ready  = in_ready_q;
  assign out_valid = out_valid_q;
  assign result    = res_q;
  assign zf        = zf_q;
  assign cf        = cf_q;
`ifdef ADDSUB_OVERFLOW_EN
  assign of        = of_q;
`else
  assign of        = 1'b0;
`endif

endmodule

// File: tb/tb_addsub_iter.sv
// Directed self-checking bench for addsub_iter (default SLICE_W=8).
// Inputs driven and outputs sampled on the falling clock edge.
module tb_addsub_iter;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] a;
  logic [31:0] b;
  logic        sub;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] result;
  logic        zf;
  logic        cf;
  logic        of;

  int n_chk  = 0;
  int n_fail = 0;
  int cyc;

`ifdef ADDSUB_OVERFLOW_EN
  localparam logic OF_EXP = 1'b1;
`else
  localparam logic OF_EXP = 1'b0;
`endif

  addsub_iter #(.SLICE_W(8)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .a         (a),
    .b         (b),
    .sub       (sub),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .result    (result),
    .zf        (zf),
    .cf        (cf),
    .of        (of)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Present one request at a falling edge; returns one edge after accept.
  task automatic send(input logic [31:0] av, input logic [31:0] bv,
                      input logic sv);
    @(negedge clk);
    in_valid = 1'b1;
    a        = av;
    b        = bv;
    sub      = sv;
    @(negedge clk);
    in_valid = 1'b0;
    a        = 32'hDEAD_BEEF;
    b        = 32'hCAFE_F00D;
    sub      = ~sv;
  endtask

  task automatic wait_done(input int start, output int n);
    n = start;
    while (!out_valid && n < 20) begin
      @(negedge clk);
      n++;
    end
  endtask

  task automatic consume();
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
    chk("ov_low_after_take", {31'd0, out_valid}, 32'd0);
    chk("ir_high_after_take", {31'd0, in_ready}, 32'd1);
  endtask

  task automatic op_chk(input string tag, input logic [31:0] av,
                        input logic [31:0] bv, input logic sv,
                        input logic [31:0] er, input logic ez,
                        input logic ec, input logic eo);
    send(av, bv, sv);
    chk({tag, "_busy_ir"}, {31'd0, in_ready}, 32'd0);
    wait_done(0, cyc);
    chk({tag, "_lat"}, cyc, 32'd4);
    chk({tag, "_res"}, result, er);
    chk({tag, "_zf"}, {31'd0, zf}, {31'd0, ez});
    chk({tag, "_cf"}, {31'd0, cf}, {31'd0, ec});
    chk({tag, "_of"}, {31'd0, of}, {31'd0, eo});
    consume();
    chk({tag, "_idle_hold"}, result, er);
  endtask

  initial begin
    rst       = 1'b1;
    in_valid  = 1'b0;
    a         = '0;
    b         = '0;
    sub       = 1'b0;
    out_ready = 1'b0;
    #1;
    chk("rst_ir", {31'd0, in_ready}, 32'd1);
    chk("rst_ov", {31'd0, out_valid}, 32'd0);
    chk("rst_res", result, 32'd0);
    chk("rst_flags", {29'd0, zf, cf, of}, 32'd0);
    @(negedge clk);
    rst = 1'b0;

    op_chk("add53", 32'h5, 32'h3, 1'b0, 32'h8, 1'b0, 1'b0, 1'b0);
    op_chk("sub55", 32'h5, 32'h5, 1'b1, 32'h0, 1'b1, 1'b1, 1'b0);
    op_chk("sub35", 32'h3, 32'h5, 1'b1, 32'hFFFF_FFFE,
           1'b0, 1'b0, 1'b0);
    op_chk("addwrap", 32'hFFFF_FFFF, 32'h1, 1'b0, 32'h0,
           1'b1, 1'b1, 1'b0);
    op_chk("addovf", 32'h7FFF_FFFF, 32'h1, 1'b0, 32'h8000_0000,
           1'b0, 1'b0, OF_EXP);
    op_chk("subneg", 32'h8000_0000, 32'h1, 1'b1, 32'h7FFF_FFFF,
           1'b0, 1'b1, OF_EXP);

    // Request pulsed mid-operation must be ignored.
    send(32'h1234_5678, 32'h1111_1111, 1'b0);
    @(negedge clk);
    in_valid = 1'b1;
    a        = 32'hFFFF_0000;
    b        = 32'h0000_FFFF;
    sub      = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
    wait_done(2, cyc);
    chk("inj_lat", cyc, 32'd4);
    chk("inj_res", result, 32'h2345_6789);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("hold_ov", {31'd0, out_valid}, 32'd1);
      chk("hold_res", result, 32'h2345_6789);
      chk("hold_flags", {29'd0, zf, cf, of}, 32'd0);
    end
    consume();

    // Abort two cycles into BUSY.
    send(32'h0F0F_0F0F, 32'h0101_0101, 1'b0);
    @(negedge clk);
    @(negedge clk);
    rst = 1'b1;
    #1;
    chk("abort_ir", {31'd0, in_ready}, 32'd1);
    chk("abort_ov", {31'd0, out_valid}, 32'd0);
    chk("abort_res", result, 32'd0);
    @(negedge clk);
    rst = 1'b0;
    op_chk("post_rst", 32'h1, 32'h1, 1'b0, 32'h2, 1'b0, 1'b0, 1'b0);

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
